// File: rtl/time_stamp_mc.sv
// ---------------------------------------------------------------------------
// time_stamp_mc
//
// Multi-channel event time-stamper. A free-running WIDTH-bit counter runs
// while `start` is high. A rising edge on any of the NCH event inputs
// captures the counter into that channel's pending register. A fixed-priority
// arbiter (lowest channel first) moves one pending capture per cycle into a
// shared first-word-fall-through FIFO. The FIFO is drained over a
// valid/ready stream.
//
// Ports
//   CLK         in   clock, all logic on posedge
//   RST         in   synchronous, active-high reset
//   start       in   1 = counter runs and events are accepted
//   evt         in   [NCH]   event inputs, synchronous to CLK
//   clr_ovf     in   one-cycle pulse, clears overflow
//   ts_data     out  [WIDTH] timestamp at FIFO head (0 when empty)
//   ts_ch       out  [CHW]   channel id at FIFO head (0 when empty)
//   ts_valid    out  FIFO non-empty
//   ts_ready    in   head pops on ts_valid & ts_ready
//   fifo_level  out  [$clog2(DEPTH)+1] entries held, 0..DEPTH
//   overflow    out  [NCH]   sticky per-channel drop flag
//   wrap        out  one-cycle pulse in the cycle the counter reads 0
//                    after wrapping from all-ones
// ---------------------------------------------------------------------------
module time_stamp_mc #(
  parameter  int WIDTH = 16,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 16,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [NCH-1:0]   evt,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] ts_data,
  output logic [CHW-1:0]   ts_ch,
  output logic             ts_valid,
  input  logic             ts_ready,
  output logic [LW-1:0]    fifo_level,
  output logic [NCH-1:0]   overflow,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
  localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
  localparam logic [LW-1:0]    LVL_ONE    = LW'(1);
  localparam logic [LW-1:0]    LVL_FULL   = LW'(DEPTH);

  // -------------------------------------------------------------------------
  // Free-running stamp counter and wrap pulse
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] count;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of the others; = here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      // wrap is registered alongside the rollover, so it is high exactly
      // while count reads 0 after leaving all-ones.
      wrap <= start && (count == CNT_MAX);
      if (start) begin
        count <= count + CNT_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Rising-edge detection
  // -------------------------------------------------------------------------
  logic [NCH-1:0] evt_d;
  logic [NCH-1:0] edge_det;

  // evt_d tracks evt during reset as well, so a level already high when
  // reset is released is not seen as an edge. Likewise while start=0.
  always_ff @(posedge CLK) begin
    evt_d <= evt;
  end

  assign edge_det = evt & ~evt_d & {NCH{start}};

  // -------------------------------------------------------------------------
  // Per-channel pending registers
  // -------------------------------------------------------------------------
  logic [NCH-1:0]   pend_vld;
  logic [WIDTH-1:0] pend_ts [NCH];

  // -------------------------------------------------------------------------
  // Fixed-priority arbiter: lowest-index valid pending channel wins
  // -------------------------------------------------------------------------
  logic [NCH-1:0]   grant;
  logic [CHW-1:0]   sel_ch;
  logic [WIDTH-1:0] sel_ts;
  logic             found;

  // NOTE: every always_comb output gets a default before any condition, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant  = '0;
    sel_ch = '0;
    sel_ts = '0;
    found  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pend_vld[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        sel_ch   = CHW'(i);
        sel_ts   = pend_ts[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic [NCH-1:0]   drain;
  logic [NCH-1:0]   ovf_set;

  assign full  = (level == LVL_FULL);
  assign empty = (level == '0);

  // A full FIFO refuses the write even when the head is popped in the same
  // cycle; the pending registers simply hold one more cycle.
  assign wr_en = found && !full;
  assign rd_en = !empty && ts_ready;

  assign drain = grant & {NCH{wr_en}};

  // A new edge is dropped only if the channel still holds a capture that is
  // not leaving this cycle.
  assign ovf_set = edge_det & pend_vld & ~drain;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_vld <= '0;
      overflow <= '0;
      for (int i = 0; i < NCH; i++) begin
        pend_ts[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (edge_det[i] && (!pend_vld[i] || drain[i])) begin
          pend_vld[i] <= 1'b1;
          pend_ts[i]  <= count;
        end else if (drain[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
      // Set has priority over a coincident clear.
      overflow <= (overflow & ~{NCH{clr_ovf}}) | ovf_set;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_ts [DEPTH];
  logic [CHW-1:0]   mem_ch [DEPTH];

  // NOTE: the storage array has no reset. Only pointers and level are
  // cleared; stale words are never visible because the outputs are gated
  // by ts_valid.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_ts[wr_ptr] <= sel_ts;
      mem_ch[wr_ptr] <= sel_ch;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (first-word-fall-through)
  // -------------------------------------------------------------------------
  assign ts_valid   = !empty;
  assign ts_data    = empty ? '0 : mem_ts[rd_ptr];
  assign ts_ch      = empty ? '0 : mem_ch[rd_ptr];
  assign fifo_level = level;

endmodule
